axi_lite_intr_responder: RTL and testbench

- AXI4-Lite slave interrupt controller. It is the responder for the interrupt register accesses issued by the PS or by the bench master agent.
- It latches PL interrupt source events into a status register, masks them with per-source and global enables, and drives a single irq line towards the PS.
- Software clears latched events by writing the acknowledge register.
- It sits inside the PLtoPSInterrupt IP, beside the S00 data-register slave.

---
 rtl/axi_lite_intr_responder_pkg.sv | 26 ++
 rtl/axi_lite_intr_responder_intr_detect.sv | 31 +++
 rtl/axi_lite_intr_responder.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_intr_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_intr_responder_pkg.sv
// Shared register map, response codes and channel FSM states for the
// AXI4-Lite interrupt responder.
package axi_lite_intr_pkg;

  localparam logic [4:0] ADDR_GIE = 5'h00;
  localparam logic [4:0] ADDR_IER = 5'h04;
  localparam logic [4:0] ADDR_ISR = 5'h08;
  localparam logic [4:0] ADDR_IAR = 5'h0C;
  localparam logic [4:0] ADDR_IPR = 5'h10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  // Expand the four byte strobes into a 32-bit per-bit write mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_lite_intr_responder_intr_detect.sv
// Per-source edge/level event detection and the latched interrupt status
// register with write-1-to-clear; a new event wins over a same-cycle clear.
module intr_detect #(
  parameter int C_NUM_INTR  = 1,
  parameter int C_INTR_EDGE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [C_NUM_INTR-1:0] intr_src,
  input  logic [C_NUM_INTR-1:0] clr,
  output logic [C_NUM_INTR-1:0] isr
);

  logic [C_NUM_INTR-1:0] src_d;
  logic [C_NUM_INTR-1:0] evt;

  always_comb begin
    evt = (C_INTR_EDGE != 0) ? (intr_src & ~src_d) : intr_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_d <= '0;
      isr   <= '0;
    end else begin
      src_d <= intr_src;
      isr   <= (isr & ~clr) | evt;
    end
  end

endmodule

// File: rtl/axi_lite_intr_responder.sv
// AXI4-Lite slave interrupt controller: GIE/IER/ISR/IAR/IPR registers and a
// single registered irq line towards the PS.
module axi_lite_intr_responder
  import axi_lite_intr_pkg::*;
#(
  parameter int C_NUM_INTR         = 1,
  parameter int C_ADDR_WIDTH       = 5,
  parameter int C_INTR_EDGE        = 1,
  parameter int C_IRQ_SENSITIVITY  = 1,
  parameter int C_IRQ_ACTIVE_STATE = 1
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [C_ADDR_WIDTH-1:0] AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [31:0]             WDATA,
  input  logic [3:0]              WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [C_ADDR_WIDTH-1:0] ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [31:0]             RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  input  logic [C_NUM_INTR-1:0]   intr_src,
  output logic                    irq
);

  localparam logic IRQ_ON = C_IRQ_ACTIVE_STATE[0];

  wr_state_e             wr_state, wr_state_nxt;
  rd_state_e             rd_state, rd_state_nxt;
  logic                  wr_en, rd_en;
  logic [4:0]            wr_off, rd_off;
  logic [31:0]           wmask;
  logic                  gie;
  logic [C_NUM_INTR-1:0] ier, isr, iar_clr;
  logic                  active, active_q, irq_q;
  logic [31:0]           rd_mux, rdata_q;
  logic                  unused_addr_lsbs;

  assign wr_off           = {AWADDR[4:2], 2'b00};
  assign rd_off           = {ARADDR[4:2], 2'b00};
  assign wmask            = strb_mask(WSTRB);
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  assign BRESP = RESP_OKAY;
  assign RRESP = RESP_OKAY;
  assign RDATA = rdata_q;
  assign irq   = irq_q;

  // Write channel: ready is offered combinationally in idle so a write can
  // complete every second cycle.
  always_comb begin
    wr_state_nxt = wr_state;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    wr_en        = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (AWVALID && WVALID) begin
          AWREADY      = 1'b1;
          WREADY       = 1'b1;
          wr_en        = 1'b1;
          wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_state_nxt = W_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    ARREADY      = 1'b0;
    RVALID       = 1'b0;
    rd_en        = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ARVALID) begin
          ARREADY      = 1'b1;
          rd_en        = 1'b1;
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY) rd_state_nxt = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      gie <= 1'b0;
      ier <= '0;
    end else if (wr_en) begin
      case (wr_off)
        ADDR_GIE: if (WSTRB[0]) gie <= WDATA[0];
        ADDR_IER: ier <= C_NUM_INTR'((32'(ier) & ~wmask) | (WDATA & wmask));
        default: ;
      endcase
    end
  end

  assign iar_clr = (wr_en && (wr_off == ADDR_IAR)) ? C_NUM_INTR'(WDATA & wmask) : '0;

  intr_detect #(
    .C_NUM_INTR (C_NUM_INTR),
    .C_INTR_EDGE(C_INTR_EDGE)
  ) u_intr_detect (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .intr_src(intr_src),
    .clr     (iar_clr),
    .isr     (isr)
  );

  always_comb begin
    rd_mux = '0;
    case (rd_off)
      ADDR_GIE: rd_mux[0] = gie;
      ADDR_IER: rd_mux    = 32'(ier);
      ADDR_ISR: rd_mux    = 32'(isr);
      ADDR_IPR: rd_mux    = 32'(isr & ier);
      default:  rd_mux    = '0;
    endcase
  end

  // Sampled at the AR handshake, so a same-cycle IAR write reads pre-clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= rd_mux;
    end
  end

  assign active = gie & (|(isr & ier));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      active_q <= 1'b0;
      irq_q    <= ~IRQ_ON;
    end else begin
      active_q <= active;
      if (C_IRQ_SENSITIVITY != 0) begin
        irq_q <= active ? IRQ_ON : ~IRQ_ON;
      end else begin
        irq_q <= (active && !active_q) ? IRQ_ON : ~IRQ_ON;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_intr_responder.sv
// Directed self-checking bench for axi_lite_intr_responder; read data is
// checked against a queue of expected values filled when each read is issued.
module tb_axi_lite_intr_responder;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [4:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [4:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic [0:0]  intr_src;
  logic        irq;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd;

  always #5 ACLK = ~ACLK;

  axi_lite_intr_responder #(
    .C_NUM_INTR        (1),
    .C_ADDR_WIDTH      (5),
    .C_INTR_EDGE       (1),
    .C_IRQ_SENSITIVITY (1),
    .C_IRQ_ACTIVE_STATE(1)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .intr_src(intr_src),
    .irq     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned n = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    while (!(AWREADY && WREADY) && n < 16) begin
      @(negedge ACLK);
      n++;
    end
    chk("wr_accept", 32'(AWREADY && WREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    chk("bvalid_latency", 32'(BVALID), 32'd1);
    chk("bresp", 32'(BRESP), 32'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input string tag, input logic [4:0] a, input logic [31:0] e);
    int unsigned n = 0;
    exp_q.push_back(e);
    ARADDR = a; ARVALID = 1'b1;
    @(negedge ACLK);
    while (!ARREADY && n < 16) begin
      @(negedge ACLK);
      n++;
    end
    chk("rd_accept", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rvalid_latency", 32'(RVALID), 32'd1);
    chk("rresp", 32'(RRESP), 32'd0);
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    chk(tag, RDATA, exp_rd);
    @(posedge ACLK); #1;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    @(negedge ACLK);
    chk(tag, 32'(irq), 32'(exp));
    @(posedge ACLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1; intr_src = '0;

    // Reset state
    @(negedge ACLK);
    chk("rst_awready", 32'(AWREADY), 32'd0);
    chk("rst_bvalid",  32'(BVALID),  32'd0);
    chk("rst_arready", 32'(ARREADY), 32'd0);
    chk("rst_rvalid",  32'(RVALID),  32'd0);
    chk("rst_rdata",   RDATA,        32'd0);
    chk("rst_irq",     32'(irq),     32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    @(posedge ACLK); #1;

    axi_read("rd_gie_rst", 5'h00, 32'h0);
    axi_read("rd_ier_rst", 5'h04, 32'h0);
    axi_read("rd_isr_rst", 5'h08, 32'h0);
    axi_read("rd_iar_rst", 5'h0C, 32'h0);
    axi_read("rd_ipr_rst", 5'h10, 32'h0);
    chk_irq("irq_after_rst", 1'b0);

    // Enabled source pulse: irq two edges after the sampled rising edge
    axi_write(5'h00, 32'h1, 4'hF);
    axi_write(5'h04, 32'h1, 4'hF);
    intr_src = 1'b1;
    @(posedge ACLK); #1;
    intr_src = 1'b0;
    @(negedge ACLK);
    chk("irq_latency_1", 32'(irq), 32'd0);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("irq_latency_2", 32'(irq), 32'd1);
    @(posedge ACLK); #1;
    axi_read("rd_ipr_set", 5'h10, 32'h1);
    axi_read("rd_isr_set", 5'h08, 32'h1);
    axi_write(5'h0C, 32'h1, 4'hF);
    chk_irq("irq_after_iar", 1'b0);
    axi_read("rd_ipr_clr", 5'h10, 32'h0);
    axi_read("rd_isr_clr", 5'h08, 32'h0);

    // Masked source latches but does not raise irq
    axi_write(5'h04, 32'h0, 4'hF);
    intr_src = 1'b1;
    chk_irq("irq_masked", 1'b0);
    axi_read("rd_isr_masked", 5'h08, 32'h1);
    axi_read("rd_ipr_masked", 5'h10, 32'h0);
    chk_irq("irq_masked_2", 1'b0);
    axi_write(5'h04, 32'h1, 4'hF);
    chk_irq("irq_on_ier", 1'b1);
    axi_write(5'h00, 32'h0, 4'hF);
    chk_irq("irq_gie_off", 1'b0);
    axi_read("rd_isr_gie_off", 5'h08, 32'h1);
    axi_write(5'h00, 32'h1, 4'hF);
    chk_irq("irq_gie_on", 1'b1);
    intr_src = 1'b0;
    axi_write(5'h0C, 32'h1, 4'hF);
    chk_irq("irq_cleared", 1'b0);

    // Write response back-pressure with a second write pending
    BREADY = 1'b0;
    AWADDR = 5'h04; WDATA = 32'h1; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    chk("bp_wr_accept", 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_bvalid_hold", 32'(BVALID), 32'd1);
      chk("bp_no_awready", 32'(AWREADY), 32'd0);
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    chk("bp_bvalid_release", 32'(BVALID), 32'd1);
    @(posedge ACLK); #1;

    // Read data back-pressure
    RREADY = 1'b0;
    exp_q.push_back(32'h1);
    ARADDR = 5'h00; ARVALID = 1'b1;
    @(negedge ACLK);
    chk("bp_rd_accept", 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bp_rvalid_hold", 32'(RVALID), 32'd1);
      chk("bp_no_arready", 32'(ARREADY), 32'd0);
      chk("bp_rdata_stable", RDATA, exp_rd);
      @(posedge ACLK); #1;
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge ACLK);
    chk("bp_rvalid_release", 32'(RVALID), 32'd1);
    @(posedge ACLK); #1;

    // Same-cycle event and IAR clear: set wins
    intr_src = 1'b1;
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read("rd_isr_set_wins", 5'h08, 32'h1);
    intr_src = 1'b0;
    axi_write(5'h0C, 32'h1, 4'hF);
    axi_read("rd_isr_after_clr", 5'h08, 32'h0);

    // Byte strobes and unimplemented bits
    axi_write(5'h04, 32'h0, 4'b1110);
    axi_read("rd_ier_strb", 5'h04, 32'h1);
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF);
    axi_read("rd_ier_width", 5'h04, 32'h1);
    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF);
    axi_read("rd_gie_width", 5'h00, 32'h1);

    // Unmapped offset
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF);
    axi_read("rd_unmapped", 5'h14, 32'h0);
    axi_read("rd_iar_zero", 5'h0C, 32'h0);

    // Reset with a read outstanding
    RREADY = 1'b0;
    ARADDR = 5'h04; ARVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rst_rd_pending", 32'(RVALID), 32'd1);
    ARESETN = 1'b0;
    #1;
    chk("rst_rvalid_abort", 32'(RVALID), 32'd0);
    chk("rst_rdata_clear", RDATA, 32'd0);
    chk("rst_irq_clear", 32'(irq), 32'd0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    RREADY = 1'b1;
    @(posedge ACLK); #1;
    axi_read("rd_gie_post_rst", 5'h00, 32'h0);
    axi_read("rd_ier_post_rst", 5'h04, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
